// File: rtl/gemm_tile_col2im_writer_if.sv
// gemm_tile_col2im_writer_if
//   Bundles the tile-row stream coming from the systolic controller and the
//   single-port SRAM write bus leaving the col2im writer.
//
//   in_valid / in_ready : tile-row handshake (producer -> writer)
//   in_m0 / in_n0       : tile base row / column, meaningful on row 0 of a tile
//   in_row              : one C-tile row, element j belongs to column n0+j
//   wr_en / wr_addr     : SRAM write strobe and flat CHW address (n*M_TOTAL+m)
//   wr_data             : requantised element
//
//   master : the testbench / controller side (drives the row stream, observes writes)
//   slave  : the col2im writer itself
interface gemm_tile_col2im_writer_if #(
  parameter int DATA_W_P = 16,
  parameter int ACC_W_P  = 32,
  parameter int SA_COLS  = 16,
  parameter int M_TOTAL  = 3136,
  parameter int N_TOTAL  = 64
);
  localparam int MW = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1;
  localparam int NW = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1;
  localparam int AW = (M_TOTAL * N_TOTAL > 1) ? $clog2(M_TOTAL * N_TOTAL) : 1;

  logic                              in_valid;
  logic                              in_ready;
  logic [MW-1:0]                     in_m0;
  logic [NW-1:0]                     in_n0;
  logic [SA_COLS-1:0][ACC_W_P-1:0]   in_row;
  logic                              wr_en;
  logic [AW-1:0]                     wr_addr;
  logic signed [DATA_W_P-1:0]        wr_data;

  modport master (
    output in_valid, in_m0, in_n0, in_row,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_m0, in_n0, in_row,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/gemm_tile_col2im_writer.sv
// gemm_tile_col2im_writer
//   Drains GEMM result tiles one tile row at a time and scatters each element
//   into a flat CHW output feature map at address n*M_TOTAL + m, applying an
//   optional ReLU followed by an arithmetic right shift and saturation to
//   DATA_W_P bits. One row costs one accept cycle plus SA_COLS write cycles;
//   elements falling outside M_TOTAL x N_TOTAL use their cycle but do not write.
//
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start_i         : one-cycle pulse starting a layer (only in IDLE or DONE)
//   cfg_relu_en_i   : clamp negatives to zero, sampled on start
//   cfg_shift_i     : arithmetic right shift amount, sampled on start
//   bus (slave)     : tile-row handshake in, registered SRAM write bus out
//   busy_o          : high while accepting or writing rows
//   done_o          : high once every tile has been written, until next start
module gemm_tile_col2im_writer #(
  parameter int DATA_W_P = 16,
  parameter int ACC_W_P  = 32,
  parameter int SA_ROWS  = 16,
  parameter int SA_COLS  = 16,
  parameter int M_TOTAL  = 3136,
  parameter int N_TOTAL  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     cfg_relu_en_i,
  input  logic [4:0]               cfg_shift_i,
  gemm_tile_col2im_writer_if.slave bus,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int MT    = (M_TOTAL + SA_ROWS - 1) / SA_ROWS;
  localparam int NT    = (N_TOTAL + SA_COLS - 1) / SA_COLS;
  localparam int TILES = MT * NT;
  localparam int MW    = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1;
  localparam int NW    = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1;
  localparam int AW    = (M_TOTAL * N_TOTAL > 1) ? $clog2(M_TOTAL * N_TOTAL) : 1;
  localparam int RW    = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1;
  localparam int CW    = (SA_COLS > 1) ? $clog2(SA_COLS) : 1;
  localparam int TW    = $clog2(TILES + 1);

  localparam logic [RW-1:0] R_LAST = RW'(SA_ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SA_COLS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TILES - 1);

  // Saturation bounds expressed at accumulator width; the minimum is the
  // bitwise complement of the maximum in two's complement.
  localparam logic signed [ACC_W_P-1:0] SAT_MAX =
    ACC_W_P'((64'sd1 <<< (DATA_W_P - 1)) - 64'sd1);
  localparam logic signed [ACC_W_P-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  state_t                           state_q, state_d;
  logic [RW-1:0]                    r_q, r_d;
  logic [CW-1:0]                    c_q, c_d;
  logic [TW-1:0]                    t_q, t_d;
  logic [MW-1:0]                    m0_q, m0_d;
  logic [NW-1:0]                    n0_q, n0_d;
  logic [31:0]                      m_q, m_d;
  logic                             relu_q, relu_d;
  logic [4:0]                       shift_q, shift_d;
  logic [SA_COLS-1:0][ACC_W_P-1:0]  rowBuf_q, rowBuf_d;
  logic                             wrEn_q, wrEn_d;
  logic [AW-1:0]                    wrAddr_q, wrAddr_d;
  logic signed [DATA_W_P-1:0]       wrData_q, wrData_d;

  logic                             inReady;
  logic                             selValid;
  logic signed [ACC_W_P-1:0]        selX;
  logic [31:0]                      selM;
  logic [31:0]                      selN;
  logic signed [ACC_W_P-1:0]        reluX;
  logic signed [ACC_W_P-1:0]        shiftX;
  logic                             inRange;

  // State, counters, row buffer and the registered write bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      c_q      <= '0;
      t_q      <= '0;
      m0_q     <= '0;
      n0_q     <= '0;
      m_q      <= '0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      rowBuf_q <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      t_q      <= t_d;
      m0_q     <= m0_d;
      n0_q     <= n0_d;
      m_q      <= m_d;
      relu_q   <= relu_d;
      shift_q  <= shift_d;
      rowBuf_q <= rowBuf_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  // Next-state logic. The element that will appear on the write bus in the
  // following cycle is selected here: column 0 comes straight from in_row on
  // the handshake so it is already registered in the first WRITE cycle, and
  // each WRITE cycle with column c preloads column c+1 from the row buffer.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    t_d      = t_q;
    m0_d     = m0_q;
    n0_d     = n0_q;
    m_d      = m_q;
    relu_d   = relu_q;
    shift_d  = shift_q;
    rowBuf_d = rowBuf_q;
    inReady  = 1'b0;
    selValid = 1'b0;
    selX     = '0;
    selM     = '0;
    selN     = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = ACCEPT;
          r_d     = '0;
          c_d     = '0;
          t_d     = '0;
          relu_d  = cfg_relu_en_i;
          shift_d = cfg_shift_i;
        end
      end

      ACCEPT: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          rowBuf_d = bus.in_row;
          // Tile coordinates are only trusted on the first row of a tile.
          if (r_q == '0) begin
            m0_d = bus.in_m0;
            n0_d = bus.in_n0;
          end
          m_d      = 32'(m0_d) + 32'(r_q);
          c_d      = '0;
          state_d  = WRITE;
          selValid = 1'b1;
          selX     = bus.in_row[0];
          selM     = m_d;
          selN     = 32'(n0_d);
        end
      end

      WRITE: begin
        if (c_q == C_LAST) begin
          if (r_q == R_LAST) begin
            r_d     = '0;
            t_d     = t_q + TW'(1);
            state_d = (t_q == T_LAST) ? DONE : ACCEPT;
          end else begin
            r_d     = r_q + RW'(1);
            state_d = ACCEPT;
          end
        end else begin
          c_d      = c_q + CW'(1);
          selValid = 1'b1;
          selX     = rowBuf_q[c_d];
          selM     = m_q;
          selN     = 32'(n0_q) + 32'(c_d);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Requantisation of the selected element: ReLU, floor shift, saturate.
  // Edge tiles past M_TOTAL or N_TOTAL still take their cycle but never write.
  always_comb begin
    reluX    = (relu_q && selX[ACC_W_P-1]) ? '0 : selX;
    shiftX   = reluX >>> shift_q;
    inRange  = (selM < 32'(M_TOTAL)) && (selN < 32'(N_TOTAL));
    wrEn_d   = selValid && inRange;
    wrAddr_d = '0;
    wrData_d = '0;
    if (wrEn_d) begin
      wrAddr_d = AW'(selN * 32'(M_TOTAL) + selM);
      if (shiftX > SAT_MAX) begin
        wrData_d = SAT_MAX[DATA_W_P-1:0];
      end else if (shiftX < SAT_MIN) begin
        wrData_d = SAT_MIN[DATA_W_P-1:0];
      end else begin
        wrData_d = shiftX[DATA_W_P-1:0];
      end
    end
  end

  assign bus.in_ready = inReady;
  assign bus.wr_en    = wrEn_q;
  assign bus.wr_addr  = wrAddr_q;
  assign bus.wr_data  = wrData_q;
  assign busy_o       = (state_q == ACCEPT) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_gemm_tile_col2im_writer.sv
// tb_gemm_tile_col2im_writer
//   Drives whole layers of tile rows into the col2im writer on a 20x20 output
//   with 16x16 tiles (four tiles, edge tiles partly out of range). Every
//   accepted row pushes its expected SRAM writes into a queue; a negedge
//   monitor pops and compares each write and rebuilds the memory image.
module tb_gemm_tile_col2im_writer;

  localparam int DW    = 16;
  localparam int AWD   = 32;
  localparam int SR    = 16;
  localparam int SC    = 16;
  localparam int MTOT  = 20;
  localparam int NTOT  = 20;
  localparam int TILES = 4;
  localparam int ROWS  = TILES * SR;
  localparam int MWB   = $clog2(MTOT);
  localparam int NWB   = $clog2(NTOT);
  localparam int AWB   = $clog2(MTOT * NTOT);

  typedef logic [SC-1:0][AWD-1:0] rowT;
  typedef struct {
    int          addr;
    logic [15:0] data;
  } expT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       relu = 1'b0;
  logic [4:0] shift = '0;
  logic       busy;
  logic       done;

  gemm_tile_col2im_writer_if #(
    .DATA_W_P(DW), .ACC_W_P(AWD), .SA_COLS(SC), .M_TOTAL(MTOT), .N_TOTAL(NTOT)
  ) bus ();

  gemm_tile_col2im_writer #(
    .DATA_W_P(DW), .ACC_W_P(AWD), .SA_ROWS(SR), .SA_COLS(SC),
    .M_TOTAL(MTOT), .N_TOTAL(NTOT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .cfg_relu_en_i(relu),
    .cfg_shift_i(shift),
    .bus(bus),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          cycStart = 0;
  int          writeCount = 0;
  expT         expQ[$];
  logic [15:0] mem[int];
  logic [15:0] memRef[int];
  bit          curRelu = 1'b0;
  int          curShift = 0;
  bit          spEn = 1'b0;
  int          sp0 = 0;
  int          sp1 = 0;
  int          tileM0[TILES] = '{16, 16, 0, 0};
  int          tileN0[TILES] = '{16, 0, 0, 16};

  always @(posedge clk) cyc <= cyc + 1;

  // Reference requantisation at 64-bit precision.
  function automatic logic [15:0] requant(input logic [31:0] x, input bit rl, input int sh);
    longint v;
    v = longint'($signed(x));
    if (rl && v < 0) v = 0;
    v = v >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [15:0] memAt(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'hxxxx;
  endfunction

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
      expT         e;
      logic [AWB-1:0] ea;
      writeCount++;
      tests++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%0d, required no write",
                 bus.wr_addr, $signed(bus.wr_data));
      end else begin
        e  = expQ.pop_front();
        ea = e.addr[AWB-1:0];
        if (bus.wr_addr !== ea || bus.wr_data !== e.data) begin
          fails++;
          $display("[TB] FAIL write_value: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   bus.wr_addr, $signed(bus.wr_data), ea, $signed(e.data));
        end
      end
      mem[int'(bus.wr_addr)] = bus.wr_data;
      tests++;
      if (bus.in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL ready_write_overlap: in_ready=%b while writing, required 0",
                 bus.in_ready);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic startLayer(input bit rl, input int sh);
    writeCount = 0;
    mem.delete();
    start    = 1'b1;
    relu     = rl;
    shift    = 5'(sh);
    curRelu  = rl;
    curShift = sh;
    @(negedge clk);
    start    = 1'b0;
    relu     = ~rl;
    shift    = 5'($urandom);
    cycStart = cyc;
  endtask

  // Presents one row, waits (bounded) for the handshake, pushes expectations.
  task automatic sendRow(input int m0, input int n0, input int r, input rowT row, input bit toggle);
    int  budget = 0;
    bit  v;
    rowT g;
    bus.in_row = row;
    bus.in_m0  = (r == 0) ? MWB'(m0) : MWB'($urandom);
    bus.in_n0  = (r == 0) ? NWB'(n0) : NWB'($urandom);
    v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.in_valid = v;
    while (!(v && bus.in_ready === 1'b1) && budget < 500) begin
      @(negedge clk);
      budget++;
      v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
    end
    if (!(v && bus.in_ready === 1'b1)) begin
      tests++;
      fails++;
      $display("[TB] FAIL handshake_timeout: in_ready=%b, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    for (int j = 0; j < SC; j++) begin
      expT e;
      if (m0 + r < MTOT && n0 + j < NTOT) begin
        e.addr = (n0 + j) * MTOT + (m0 + r);
        e.data = requant(row[j], curRelu, curShift);
        expQ.push_back(e);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int j = 0; j < SC; j++) g[j] = $urandom();
    bus.in_row = g;
  endtask

  // mode 0: back-to-back rows; mode 1: random in_valid and idle gaps.
  task automatic sendTile(input int ti, input int rFirst, input int rLast, input int mode);
    for (int r = rFirst; r <= rLast; r++) begin
      rowT row;
      int  m0;
      int  n0;
      m0 = tileM0[ti];
      n0 = tileN0[ti];
      for (int j = 0; j < SC; j++) row[j] = 32'(1000 * (n0 + j) + m0 + r);
      if (spEn && m0 == 0 && n0 == 0 && r == 0) begin
        row[0] = sp0;
        row[1] = sp1;
      end
      sendRow(m0, n0, r, row, mode == 1);
      if (mode == 1) repeat ((r % 2 == 1) ? 30 : $urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic waitDone(input bit checkCycles);
    int budget = 0;
    while (done !== 1'b1 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL done_timeout: done=%b, required 1", done);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_at_done: busy=%b, required 0", busy);
    end
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL missing_writes: %0d pending, required 0", expQ.size());
      expQ.delete();
    end
    tests++;
    if (writeCount != MTOT * NTOT) begin
      fails++;
      $display("[TB] FAIL write_count: got %0d, required %0d", writeCount, MTOT * NTOT);
    end
    if (checkCycles) begin
      tests++;
      if (cyc - cycStart != ROWS * (SC + 1)) begin
        fails++;
        $display("[TB] FAIL layer_cycles: got %0d, required %0d", cyc - cycStart, ROWS * (SC + 1));
      end
    end
  endtask

  task automatic runLayer(input bit rl, input int sh, input int mode, input bit checkCycles);
    startLayer(rl, sh);
    for (int ti = 0; ti < TILES; ti++) sendTile(ti, 0, SR - 1, mode);
    waitDone(checkCycles);
  endtask

  task automatic compareToRef(input string name);
    int mism = 0;
    foreach (memRef[k]) begin
      if (!mem.exists(k) || mem[k] !== memRef[k]) mism++;
    end
    tests++;
    if (mism != 0 || mem.size() != memRef.size()) begin
      fails++;
      $display("[TB] FAIL %s: %0d differing addresses, %0d entries, required 0 and %0d",
               name, mism, mem.size(), memRef.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_m0    = '0;
    bus.in_n0    = '0;
    bus.in_row   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests += 6;
    if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
    if (bus.wr_en !== 1'b0)    begin fails++; $display("[TB] FAIL reset_wr_en: got %b, required 0", bus.wr_en); end
    if (bus.wr_addr !== '0)    begin fails++; $display("[TB] FAIL reset_wr_addr: got %0d, required 0", bus.wr_addr); end
    if (bus.wr_data !== '0)    begin fails++; $display("[TB] FAIL reset_wr_data: got %0d, required 0", bus.wr_data); end
    if (busy !== 1'b0)         begin fails++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)         begin fails++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
    #2 rst_n = 1'b1;
    // in_valid while idle must be ignored.
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0 || writeCount != 0) begin
      fails++;
      $display("[TB] FAIL idle_ignores_valid: in_ready=%b writes=%0d, required 0 and 0",
               bus.in_ready, writeCount);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_layer();
    runLayer(1'b0, 0, 0, 1'b1);
    tests++;
    if (memAt(397) !== 16'd19017) begin
      fails++;
      $display("[TB] FAIL edge_element_397: got %0d, required 19017", memAt(397));
    end
    tests++;
    if (memAt(0) !== 16'd0 || memAt(399) !== 16'd19019) begin
      fails++;
      $display("[TB] FAIL corner_elements: got %0d/%0d, required 0/19019", memAt(0), memAt(399));
    end
    memRef = mem;
  endtask

  task automatic test_requant();
    spEn = 1'b1;
    sp0 = -70000; sp1 = 5;
    runLayer(1'b0, 2, 0, 1'b0);
    tests++;
    if (memAt(0) !== 16'hBBA4) begin
      fails++; $display("[TB] FAIL rq_neg_shift2: got %0d, required -17500", $signed(memAt(0)));
    end
    sp0 = -70000; sp1 = 32'h7FFF_FFFF;
    runLayer(1'b1, 0, 0, 1'b0);
    tests += 2;
    if (memAt(0) !== 16'h0000) begin
      fails++; $display("[TB] FAIL rq_relu: got %0d, required 0", $signed(memAt(0)));
    end
    if (memAt(20) !== 16'h7FFF) begin
      fails++; $display("[TB] FAIL rq_sat_pos_relu: got %0d, required 32767", $signed(memAt(20)));
    end
    sp0 = 32'h8000_0000; sp1 = 32'h7FFF_FFFF;
    runLayer(1'b0, 0, 0, 1'b0);
    tests += 2;
    if (memAt(0) !== 16'h8000) begin
      fails++; $display("[TB] FAIL rq_sat_neg: got %0d, required -32768", $signed(memAt(0)));
    end
    if (memAt(20) !== 16'h7FFF) begin
      fails++; $display("[TB] FAIL rq_sat_pos: got %0d, required 32767", $signed(memAt(20)));
    end
    sp0 = -5; sp1 = -70000;
    runLayer(1'b0, 1, 0, 1'b0);
    tests += 2;
    if (memAt(0) !== 16'hFFFD) begin
      fails++; $display("[TB] FAIL rq_floor: got %0d, required -3", $signed(memAt(0)));
    end
    if (memAt(20) !== 16'h8000) begin
      fails++; $display("[TB] FAIL rq_sat_neg_shift1: got %0d, required -32768", $signed(memAt(20)));
    end
    spEn = 1'b0;
  endtask

  task automatic test_backpressure();
    runLayer(1'b0, 0, 1, 1'b0);
    compareToRef("backpressure_image");
  endtask

  task automatic test_reset_mid();
    int wc;
    startLayer(1'b0, 0);
    sendTile(0, 0, SR - 1, 0);
    sendTile(1, 0, SR - 1, 0);
    sendTile(2, 0, 5, 0);
    repeat (7) @(negedge clk);
    // Tile 2 is (m0=0,n0=0): row 5 column 7 lands at 7*20+5.
    tests++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== AWB'(145)) begin
      fails++;
      $display("[TB] FAIL pre_reset_write: wr_en=%b addr=%0d, required 1 and 145", bus.wr_en, bus.wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 ||
        bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs: en=%b addr=%0d data=%0d rdy=%b busy=%b done=%b, required all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.in_ready, busy, done);
    end
    expQ.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wc = writeCount;
    bus.in_valid = 1'b1;
    repeat (20) @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (writeCount != wc || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL post_reset_quiet: writes=%0d busy=%b, required %0d and 0", writeCount, busy, wc);
    end
    runLayer(1'b0, 0, 0, 1'b1);
    compareToRef("rerun_after_reset");
  endtask

  task automatic test_control();
    int b = 0;
    startLayer(1'b0, 0);
    sendTile(0, 0, 3, 0);
    // start in WRITE with a different configuration.
    start = 1'b1; relu = 1'b1; shift = 5'd3;
    @(negedge clk);
    start = 1'b0;
    sendTile(0, 4, SR - 1, 0);
    while (bus.in_ready !== 1'b1 && b < 100) begin
      @(negedge clk);
      b++;
    end
    // start in ACCEPT with no row offered.
    start = 1'b1; relu = 1'b1; shift = 5'd7;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL start_while_busy: busy=%b done=%b rdy=%b, required 1/0/1", busy, done, bus.in_ready);
    end
    for (int ti = 1; ti < TILES; ti++) sendTile(ti, 0, SR - 1, 0);
    waitDone(1'b0);
    compareToRef("busy_start_ignored");
    startLayer(1'b0, 3);
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL restart_from_done: done=%b busy=%b, required 0 and 1", done, busy);
    end
    for (int ti = 0; ti < TILES; ti++) sendTile(ti, 0, SR - 1, 0);
    waitDone(1'b1);
    tests++;
    if (memAt(397) !== 16'd2377) begin
      fails++;
      $display("[TB] FAIL rerun_shift3: got %0d, required 2377", memAt(397));
    end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_requant();
    test_backpressure();
    test_reset_mid();
    test_control();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gemm_tile_col2im_writer.md
# gemm_tile_col2im_writer

Drains GEMM result tiles (C = A·B, M = output pixels, N = output channels) from the tiled systolic controller one tile row at a time and scatters them into a flat CHW output-feature-map SRAM, applying optional ReLU and shift-and-saturate requantisation to DATA_W_P. It inverts the im2col/transpose mapping on the output side (col2im). It turns a tile-row stream into single-port memory writes at address n·M_TOTAL + m, so the next layer can read a normal COUT×H_OUT×W_OUT map.

## Interface
- DATA_W_P, 16, output element width (int16)
- ACC_W_P, 32, GEMM accumulator width (int32)
- SA_ROWS, 16, rows per tile (M direction)
- SA_COLS, 16, columns per tile (N direction)
- M_TOTAL, 3136, GEMM rows = H_OUT·W_OUT
- N_TOTAL, 64, GEMM columns = COUT
- Derived: MT = ceil(M_TOTAL/SA_ROWS), NT = ceil(N_TOTAL/SA_COLS), TILES = MT·NT, AW = $clog2(M_TOTAL·N_TOTAL)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a layer; ignored unless in IDLE or DONE
- cfg_relu_en  in  1  clamp negatives to 0; sampled on start
- cfg_shift  in  5  arithmetic right shift; sampled on start
- in_valid  in  1  tile row valid
- in_ready  out  1  writer accepts a row
- in_m0  in  $clog2(M_TOTAL)  tile base row; sampled on row 0 of each tile
- in_n0  in  $clog2(N_TOTAL)  tile base column; sampled on row 0 of each tile
- in_row  in  SA_COLS×ACC_W_P signed  one C-tile row, element j = column n0+j
- wr_en  out  1  SRAM write strobe
- wr_addr  out  AW  flat CHW address = n·M_TOTAL + m
- wr_data  out  DATA_W_P signed  requantised element
- busy  out  1  high in ACCEPT or WRITE
- done  out  1  high in DONE until the next start

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE or DONE, start=1: latch cfg; clear row counter r, column counter c and tile counter t; go to ACCEPT.
- ACCEPT: in_ready=1. On in_valid&&in_ready:
  - latch in_row into the row buffer;
  - if r==0, latch m0/n0;
  - m = m0 + r;
  - go to WRITE with c=0.
- WRITE, one column per cycle:
  - n = n0 + c;
  - wr_en = (m < M_TOTAL && n < N_TOTAL); out-of-range edge elements cost a cycle but produce no write;
  - wr_addr = n·M_TOTAL + m; wr_data = sat(relu(x) >>> cfg_shift).
- End of row (c==SA_COLS-1):
  - if r==SA_ROWS-1, set r=0 and t++, else r++;
  - if t+1==TILES at the last row, go to DONE, else go to ACCEPT.
- Arithmetic:
  - ReLU first: x<0 → 0 when enabled.
  - Then arithmetic shift (floor, no rounding) on ACC_W_P.
  - Then saturate to [−2^(DATA_W_P−1), 2^(DATA_W_P−1)−1].
- Tiles may arrive in any (m0, n0) order. Only the tile count determines completion. Duplicate coordinates overwrite; no check is made.
- start while busy: ignored. in_valid outside ACCEPT: ignored (in_ready=0, nothing consumed).

## Timing
- Reset (async, any state): state=IDLE, counters=0; in_ready, wr_en, busy, done = 0; wr_addr, wr_data = 0. Reset mid-layer aborts with no further writes.
- wr_en, wr_addr, wr_data are registered.
  - Handshake at edge k: column j is driven in cycle k+1+j, for j = 0..SA_COLS-1.
  - in_ready reasserts in cycle k+SA_COLS+1.
- Throughput: exactly SA_COLS+1 cycles per row when in_valid is held high; a full layer takes TILES·SA_ROWS·(SA_COLS+1) cycles plus the start cycle.
- done rises in the cycle after the last column of the last row and stays high. busy falls in the same cycle.
- in_row, in_m0, in_n0 need to be stable only in the handshake cycle.

## Test plan
- Default parameters, all rows carry C[m][n] = 1000·n + m, relu=0, shift=0:
  - exactly 200704 writes; each address n·3136+m receives sat16(1000n+m);
  - done is high after 196·4·16·17 cycles from start.
- Edge tiles with M_TOTAL=20, N_TOTAL=20, SA=16×16:
  - 4 tiles, 64 rows;
  - writes only where m<20 and n<20, 400 writes total;
  - element (m=17, n=19) lands at address 19·20+17=397.
- Requantisation, single element:
  - x=−70000, relu=0, shift=2 → −17500;
  - x=−70000, relu=1 → 0;
  - x=0x7FFF_FFFF, shift=0 → 32767;
  - x=−2^31, shift=0 → −32768;
  - x=−5, shift=1 → −3 (floor).
- Backpressure: toggle in_valid randomly.
  - No row is lost or duplicated; in_ready never overlaps WRITE.
  - Rows arriving 30 cycles apart produce the same writes as back-to-back rows.
- Reset mid-layer: assert rst_n=0 at tile 2, row 5, column 7.
  - All outputs are 0 in the same cycle; no writes occur afterwards.
  - A fresh start then completes the full layer correctly.
- Control: start pulses while busy are ignored. A start in DONE clears done in the next cycle and reruns with the newly sampled cfg_shift=3.
